// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial WIDTH-bit adder/subtractor with a start/done handshake.
// One full-adder cell and one carry flop process the operands LSB first, one bit per clock.
// Subtraction is A + ~B + 1: B is inverted when it is latched, and the carry is seeded with 1.
// Optional build macro ADDSUB_OVF_EN adds an ovf output that reports two's-complement signed overflow.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_next;

  logic [WIDTH-1:0]   opa_reg;
  logic [WIDTH-1:0]   opb_reg;
  logic [WIDTH-1:0]   acc_reg;
  logic               carry_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   s_reg;
  logic               cout_reg;
  logic               done_reg;
`ifdef ADDSUB_OVF_EN
  logic               cin_msb_reg;
  logic               ovf_reg;
`endif

  logic               sum_bit;
  logic               carry_next;
  logic               last_bit;

  // The single full-adder cell works on the current LSBs of the operand shift registers.
  assign sum_bit    = opa_reg[0] ^ opb_reg[0] ^ carry_reg;
  assign carry_next = (opa_reg[0] & opb_reg[0]) | (opa_reg[0] & carry_reg) | (opb_reg[0] & carry_reg);
  assign last_bit   = (cnt_reg == CNT_W'(WIDTH - 1));

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign s    = s_reg;
  assign cout = cout_reg;
`ifdef ADDSUB_OVF_EN
  assign ovf  = ovf_reg;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: accept start only in IDLE, and leave SHIFT once the WIDTH-th bit is processed.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on start, shift one bit per clock, publish the result after the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_reg     <= '0;
      opb_reg     <= '0;
      acc_reg     <= '0;
      carry_reg   <= 1'b0;
      cnt_reg     <= '0;
      s_reg       <= '0;
      cout_reg    <= 1'b0;
      done_reg    <= 1'b0;
`ifdef ADDSUB_OVF_EN
      cin_msb_reg <= 1'b0;
      ovf_reg     <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            opa_reg   <= a;
            opb_reg   <= b ^ {WIDTH{sub}};
            carry_reg <= sub;
            cnt_reg   <= '0;
          end
        end
        SHIFT: begin
          acc_reg   <= {sum_bit, acc_reg[WIDTH-1:1]};
          carry_reg <= carry_next;
          opa_reg   <= opa_reg >> 1;
          opb_reg   <= opb_reg >> 1;
          cnt_reg   <= cnt_reg + CNT_W'(1);
`ifdef ADDSUB_OVF_EN
          // The carry flop holds the carry into the MSB while the MSB is being summed.
          if (last_bit) cin_msb_reg <= carry_reg;
`endif
        end
        FINISH: begin
          s_reg    <= acc_reg;
          cout_reg <= carry_reg;
          done_reg <= 1'b1;
`ifdef ADDSUB_OVF_EN
          ovf_reg  <= cin_msb_reg ^ carry_reg;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
Bit-serial WIDTH-bit adder/subtractor with a start/done handshake. It is the sequential counterpart of the team's parallel ripple adder-subtractor.
- Same operand and carry-in semantics: sub=1 selects A-B via A + ~B + 1.
- Computes one bit per clock, LSB first, using a single full-adder cell and a carry flop.
- Sits behind a register-mapped arithmetic front end where area matters more than latency.

Parameters:
WIDTH, 8, operand/result width in bits (≥2)
CNT_W, $clog2(WIDTH+1), bit counter width (derived; do not override)

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous active-low reset
start  input   1      request; sampled only in IDLE
sub    input   1      0 = A+B, 1 = A-B; sampled with start
a      input   WIDTH  operand A; sampled with start
b      input   WIDTH  operand B; sampled with start
busy   output  1      high while an operation is in progress
done   output  1      one-cycle pulse: s/cout (and ovf) valid
s      output  WIDTH  result, held until next completion
cout   output  1      carry out; for subtract, 1 = no borrow (A ≥ B unsigned)

Behaviour:
- Reset: clk and rst_n only; one clock, asynchronous active-low reset. rst_n=0 immediately forces:
  - state=IDLE; busy=0, done=0, s=0, cout=0 (and ovf=0 when compiled in);
  - internal shift registers, carry flop and counter cleared.
- States:
  - IDLE: busy=0. start=1 at an edge → latch a into opA and (b XOR {WIDTH{sub}}) into opB; carry ← sub; count ← 0; go to SHIFT.
  - SHIFT: busy=1. Each edge:
    - sum bit = opA[0]^opB[0]^carry, shifted into the MSB of the result shift register;
    - carry ← majority(opA[0], opB[0], carry); opA/opB shift right; count++.
    - When count reaches WIDTH-1 on this edge (the WIDTH-th bit), go to FINISH.
  - FINISH: busy=1. On the next edge: s ← result shift register, cout ← carry, done ← 1, go to IDLE.
- done is high for exactly the one cycle following the FINISH edge, then returns to 0.
- Latency: start sampled at edge T → done high after edge T+WIDTH+1. Throughput: one op per WIDTH+2 cycles minimum.
- A start asserted in the same cycle done is high is accepted, because the block is already in IDLE.
- start while busy=1 is ignored; no queuing. sub, a and b changes while busy have no effect.
- s and cout change only on the done edge. Between operations they hold the last result.
- Arithmetic is modulo 2^WIDTH. No saturation.
- Reset mid-operation aborts the operation. No done is produced and s returns to 0.

Optional Feature:
ADDSUB_OVF_EN
- Defined: an extra output ovf (1 bit) is added. At the done edge, ovf ← carry into MSB XOR carry out of MSB, i.e. two's-complement signed overflow.
  - The carry into the MSB is captured on the final SHIFT edge.
  - ovf is held like s and reset to 0.
- Undefined: the ovf port and its logic do not exist. The port list is exactly as above.

Test Plan:
- Reset, then sub=1, a=5, b=2, pulse start → busy=1 for WIDTH+1 cycles; done pulses once at edge T+9; s=3, cout=1.
- sub=1, a=18, b=18 → s=0, cout=1. Then sub=1, a=2, b=5 → s=253, cout=0 (borrow).
- sub=0, a=12, b=1 → s=13, cout=0. Then sub=0, a=200, b=100 → s=44, cout=1.
- Start a=12, b=1, add; pulse start again with a=99 at T+3 → ignored; result s=13. Back-to-back start on the done cycle → second result correct, WIDTH+2 cycles apart.
- Assert rst_n=0 at T+4 of an add → busy, done, s and cout are 0 immediately. After release, no spurious done, and the next op is correct.
- With ADDSUB_OVF_EN: add 100+100 → s=200, ovf=1, cout=0. Subtract 128-1 → s=127, ovf=1. Add 5+2 → ovf=0.
